// File: rtl/ysyx_23060191_axil_sram_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_23060191_axil_sram_pkg
// Shared definitions for the AXI4-Lite SRAM responder: response codes,
// read/write FSM state encodings and a response-selection helper.
// No ports (package).
// ----------------------------------------------------------------------------
package ysyx_23060191_axil_sram_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } r_state_e;

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_COMMIT = 2'd1,
        W_RESP   = 2'd2
    } w_state_e;

    // Map an address-decode hit to the AXI response code.
    function automatic logic [1:0] resp_of(input logic hit);
        return hit ? AXI_RESP_OKAY : AXI_RESP_DECERR;
    endfunction

endpackage

// File: rtl/ysyx_23060191_sram_array.sv
// ----------------------------------------------------------------------------
// ysyx_23060191_sram_array
// DEPTH x 32 synchronous storage with one registered read port and one
// byte-strobed write port. Contents are not reset.
// Ports:
//   clk        : clock
//   rd_en_i    : load rd_data_o from word rd_idx_i on this edge
//   rd_idx_i   : read word index
//   rd_data_o  : registered read data (holds until the next rd_en_i)
//   wr_en_i    : write enable
//   wr_idx_i   : write word index
//   wr_strb_i  : byte-lane enables for the write
//   wr_data_i  : write data
// A read and a write to the same word on the same edge return the old data.
// ----------------------------------------------------------------------------
module ysyx_23060191_sram_array #(
    parameter int DEPTH = 4096,
    parameter int IDX_W = 12
) (
    input  logic             clk,
    input  logic             rd_en_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [31:0]      rd_data_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [3:0]       wr_strb_i,
    input  logic [31:0]      wr_data_i
);

    logic [31:0] mem [DEPTH];
    logic [31:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (rd_en_i) begin
            rd_data_q <= mem[rd_idx_i];
        end
        if (wr_en_i) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_strb_i[i]) begin
                    mem[wr_idx_i][i*8 +: 8] <= wr_data_i[i*8 +: 8];
                end
            end
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/ysyx_23060191_axil_sram.sv
// ----------------------------------------------------------------------------
// ysyx_23060191_axil_sram
// AXI4-Lite slave memory with programmable read latency and byte-strobed
// writes. Independent read and write FSMs share one storage array.
// Ports:
//   clk, rstn                      : clock, asynchronous active-low reset
//   araddr/arvalid/arready         : read address channel
//   rdata/rresp/rvalid/rready      : read data channel
//   awaddr/awvalid/awready         : write address channel
//   wdata/wstrb/wvalid/wready      : write data channel
//   bresp/bvalid/bready            : write response channel
// Every output is a register or a decode of FSM state only.
// ----------------------------------------------------------------------------
module ysyx_23060191_axil_sram
    import ysyx_23060191_axil_sram_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    MEM_DEPTH  = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter int                    RD_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rvalid,
    input  logic                    rready,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready
);

    localparam int                    IDX_W = $clog2(MEM_DEPTH);
    localparam int                    CNT_W = $clog2(RD_LATENCY + 1);
    localparam logic [ADDR_WIDTH-1:0] SPAN  = ADDR_WIDTH'(4 * MEM_DEPTH);

    // Both bounds are checked explicitly so an address below the base cannot
    // wrap around into the window through the subtraction.
    function automatic logic addr_hit(input logic [ADDR_WIDTH-1:0] a);
        return (a >= BASE_ADDR) && ((a - BASE_ADDR) < SPAN);
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
        return IDX_W'((a - BASE_ADDR) >> 2);
    endfunction

    // ---------------- read path ----------------
    r_state_e         r_state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [IDX_W-1:0] ar_idx_q;
    logic             ar_hit_q;
    logic [1:0]       rresp_q;
    logic             rd_hit_q;   // gates array data onto rdata; 0 forces rdata=0
    logic             rd_en;
    logic [31:0]      arr_rdata;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state_q <= R_IDLE;
            cnt_q     <= '0;
            ar_idx_q  <= '0;
            ar_hit_q  <= 1'b0;
            rresp_q   <= AXI_RESP_OKAY;
            rd_hit_q  <= 1'b0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (arvalid) begin
                        ar_idx_q  <= addr_idx(araddr);
                        ar_hit_q  <= addr_hit(araddr);
                        cnt_q     <= CNT_W'(RD_LATENCY - 1);
                        r_state_q <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (cnt_q == '0) begin
                        rresp_q   <= resp_of(ar_hit_q);
                        rd_hit_q  <= ar_hit_q;
                        r_state_q <= R_RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                R_RESP: begin
                    if (rready) begin
                        r_state_q <= R_IDLE;
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    // The array's own read register is loaded on the same edge that moves
    // the FSM to R_RESP, so it lines up with rresp_q.
    assign rd_en   = (r_state_q == R_WAIT) && (cnt_q == '0) && ar_hit_q;
    assign arready = (r_state_q == R_IDLE);
    assign rvalid  = (r_state_q == R_RESP);
    assign rresp   = rresp_q;
    assign rdata   = rd_hit_q ? arr_rdata : '0;

    // ---------------- write path ----------------
    w_state_e         w_state_q;
    logic             aw_got_q;
    logic             w_got_q;
    logic [IDX_W-1:0] aw_idx_q;
    logic             aw_hit_q;
    logic [31:0]      wdata_q;
    logic [3:0]       wstrb_q;
    logic [1:0]       bresp_q;
    logic             wr_en;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_state_q <= W_IDLE;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            aw_idx_q  <= '0;
            aw_hit_q  <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= AXI_RESP_OKAY;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    if (awvalid && !aw_got_q) begin
                        aw_idx_q <= addr_idx(awaddr);
                        aw_hit_q <= addr_hit(awaddr);
                        aw_got_q <= 1'b1;
                    end
                    if (wvalid && !w_got_q) begin
                        wdata_q <= wdata;
                        wstrb_q <= wstrb;
                        w_got_q <= 1'b1;
                    end
                    // Leaving IDLE clears the capture flags; these later
                    // assignments override the sets above.
                    if ((aw_got_q || awvalid) && (w_got_q || wvalid)) begin
                        aw_got_q  <= 1'b0;
                        w_got_q   <= 1'b0;
                        w_state_q <= W_COMMIT;
                    end
                end
                W_COMMIT: begin
                    bresp_q   <= resp_of(aw_hit_q);
                    w_state_q <= W_RESP;
                end
                W_RESP: begin
                    if (bready) begin
                        w_state_q <= W_IDLE;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    assign wr_en   = (w_state_q == W_COMMIT) && aw_hit_q;
    assign awready = (w_state_q == W_IDLE) && !aw_got_q;
    assign wready  = (w_state_q == W_IDLE) && !w_got_q;
    assign bvalid  = (w_state_q == W_RESP);
    assign bresp   = bresp_q;

    ysyx_23060191_sram_array #(
        .DEPTH (MEM_DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk       (clk),
        .rd_en_i   (rd_en),
        .rd_idx_i  (ar_idx_q),
        .rd_data_o (arr_rdata),
        .wr_en_i   (wr_en),
        .wr_idx_i  (aw_idx_q),
        .wr_strb_i (wstrb_q),
        .wr_data_i (wdata_q)
    );

endmodule
